// File: rtl/aes_byte_sequencer_if.sv
// Byte-stream handshake bundle between the pins and aes_byte_sequencer:
// input stream, output stream, abort and status.
interface aes_byte_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       in_key;
    logic       mode_dec;
    logic       clear;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_data, in_valid, in_key, mode_dec, clear, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, in_key, mode_dec, clear, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/aes_byte_sequencer.sv
// Byte-serial load / multicycle settle / byte-serial unload around a combinational AES-128 core.
// Define AES_SEQ_DECRYPT_EN to honour mode_dec; otherwise only the encrypt result is ever captured.
module aes_byte_sequencer #(
    parameter int unsigned  CORE_LAT  = 4,
    parameter logic [127:0] RESET_KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_byte_sequencer_if.slave  bus,
    output logic [127:0]         core_text,
    output logic [127:0]         core_key,
    input  logic [127:0]         core_enc_result,
    input  logic [127:0]         core_dec_result
);
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    localparam logic [3:0] RUN_LAST = 4'(CORE_LAT - 1);

    state_e       state_q, state_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [3:0]   run_cnt_q, run_cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] shadow_q, shadow_d;
    logic [127:0] text_q, text_d;
    logic [127:0] out_shift_q, out_shift_d;
    logic         is_key_q, is_key_d;
    logic         out_valid_q, out_valid_d;

    logic         in_ready;
    logic         in_hs;
    logic         first_byte;
    logic         last_byte;
    logic         blk_is_key;
    logic [127:0] result;

    assign in_ready   = (state_q == LOAD);
    assign in_hs      = bus.in_valid & in_ready;
    assign first_byte = (byte_cnt_q == 4'd0);
    assign last_byte  = (byte_cnt_q == 4'd15);
    // The block type is only known from the live input on byte 0.
    assign blk_is_key = first_byte ? bus.in_key : is_key_q;

`ifdef AES_SEQ_DECRYPT_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (in_hs && first_byte && !bus.clear) begin
            mode_d = bus.mode_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign result = mode_q ? core_dec_result : core_enc_result;
`else
    logic unused_dec;
    assign unused_dec = ^{core_dec_result, bus.mode_dec};
    assign result     = core_enc_result;
`endif

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        run_cnt_d   = run_cnt_q;
        key_d       = key_q;
        shadow_d    = shadow_q;
        text_d      = text_q;
        out_shift_d = out_shift_q;
        is_key_d    = is_key_q;
        out_valid_d = out_valid_q;

        if (bus.clear) begin
            // Abort wins over any handshake in the same cycle.
            state_d     = LOAD;
            byte_cnt_d  = 4'd0;
            run_cnt_d   = 4'd0;
            out_valid_d = 1'b0;
            shadow_d    = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        if (first_byte) begin
                            is_key_d = bus.in_key;
                        end
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (blk_is_key) begin
                            if (last_byte) begin
                                key_d    = {shadow_q[119:0], bus.in_data};
                                shadow_d = '0;
                            end else begin
                                shadow_d = {shadow_q[119:0], bus.in_data};
                            end
                        end else begin
                            text_d = {text_q[119:0], bus.in_data};
                            if (last_byte) begin
                                state_d   = RUN;
                                run_cnt_d = 4'd0;
                            end
                        end
                    end
                end
                RUN: begin
                    run_cnt_d = run_cnt_q + 4'd1;
                    if (run_cnt_q == RUN_LAST) begin
                        out_shift_d = result;
                        out_valid_d = 1'b1;
                        run_cnt_d   = 4'd0;
                        state_d     = UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_shift_d = {out_shift_q[119:0], 8'h00};
                        byte_cnt_d  = byte_cnt_q + 4'd1;
                        if (last_byte) begin
                            out_valid_d = 1'b0;
                            state_d     = LOAD;
                        end
                    end
                end
                default: begin
                    state_d    = LOAD;
                    byte_cnt_d = 4'd0;
                    run_cnt_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            byte_cnt_q  <= 4'd0;
            run_cnt_q   <= 4'd0;
            key_q       <= RESET_KEY;
            shadow_q    <= '0;
            text_q      <= '0;
            out_shift_q <= '0;
            is_key_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            run_cnt_q   <= run_cnt_d;
            key_q       <= key_d;
            shadow_q    <= shadow_d;
            text_q      <= text_d;
            out_shift_q <= out_shift_d;
            is_key_q    <= is_key_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q != LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_shift_q[127:120];
    assign core_text     = text_q;
    assign core_key      = key_q;
endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Bench for aes_byte_sequencer: a lookup-table AES core stub (FIPS-197 vectors) plus a
// byte-queue scoreboard checked every cycle, and directed scenarios with literal results.
module tb_aes_byte_sequencer;
    localparam int           CORE_LAT  = 4;
    localparam logic [127:0] RESET_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_byte_sequencer_if bus();
    logic [127:0] core_text, core_key, core_enc_result, core_dec_result;

    // Known vectors answer exactly; anything else gets an order-sensitive scramble.
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] t);
        if (k == RESET_KEY && t == PT0) return CT0;
        if (k == KEY1 && t == PT1) return CT1;
        return t ^ {k[63:0], k[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_a5a5_0f0f_3c3c_9696;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] t);
        if (k == RESET_KEY && t == CT0) return PT0;
        if (k == KEY1 && t == CT1) return PT1;
        return ~t ^ k;
    endfunction

    assign core_enc_result = aes_enc(core_key, core_text);
    assign core_dec_result = aes_dec(core_key, core_text);

    aes_byte_sequencer #(.CORE_LAT(CORE_LAT), .RESET_KEY(RESET_KEY)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .core_text       (core_text),
        .core_key        (core_key),
        .core_enc_result (core_enc_result),
        .core_dec_result (core_dec_result)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- scoreboard model ----------------
    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] model_key = RESET_KEY;
    logic [127:0] blk_text  = '0;
    logic [127:0] ld_buf    = '0;
    int           ld_cnt    = 0;
    logic         ld_key    = 1'b0;
    logic         ld_dec    = 1'b0;
    logic [7:0]   exp_q[$];
    logic [127:0] out_cap   = '0;
    int           acc_edge  = 0;
    logic         prev_ov   = 1'b0;

    always @(negedge clk) begin
        logic [127:0] r;
        if (!rst_n) begin
            model_key = RESET_KEY;
            blk_text  = '0;
            ld_cnt    = 0;
            prev_ov   = 1'b0;
            exp_q.delete();
        end else begin
            chk("in_ready", 128'(bus.in_ready), 128'(!bus.busy));
            chk("busy", 128'(bus.busy), 128'(exp_q.size() != 0));
            chk("core_key", core_key, model_key);
            if (bus.busy) chk("core_text", core_text, blk_text);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) timeout("out_data_unexpected");
                else chk("out_data", 128'(bus.out_data), 128'(exp_q[0]));
                if (!prev_ov) chk("latency", 128'(cyc - acc_edge), 128'(CORE_LAT));
            end
            prev_ov = bus.out_valid;

            if (bus.clear) begin
                exp_q.delete();
                ld_cnt = 0;
            end else begin
                if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                    out_cap = {out_cap[119:0], bus.out_data};
                    void'(exp_q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (ld_cnt == 0) begin
                        ld_key = bus.in_key;
`ifdef AES_SEQ_DECRYPT_EN
                        ld_dec = bus.mode_dec;
`else
                        ld_dec = 1'b0;
`endif
                    end
                    ld_buf = {ld_buf[119:0], bus.in_data};
                    ld_cnt++;
                    if (ld_cnt == 16) begin
                        ld_cnt = 0;
                        if (ld_key) begin
                            model_key = ld_buf;
                        end else begin
                            blk_text = ld_buf;
                            r = ld_dec ? aes_dec(model_key, ld_buf) : aes_enc(model_key, ld_buf);
                            for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
                            acc_edge = cyc + 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_part(input logic [127:0] blk, input logic k, input logic d,
                             input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int n;
            bus.in_data  = blk[127-8*i -: 8];
            bus.in_valid = 1'b1;
            bus.in_key   = k;
            bus.mode_dec = d;
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) timeout("in_ready");
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_key   = 1'b0;
        bus.mode_dec = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n <= 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n > 200) timeout(name);
    endtask

    task automatic pulse_clear();
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hee;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clear_in_ready", 128'(bus.in_ready), 128'(1));
        chk("clear_out_valid", 128'(bus.out_valid), 128'(0));
        chk("clear_busy", 128'(bus.busy), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_key    = 1'b0;
        bus.mode_dec  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_out_data", 128'(bus.out_data), 128'(0));
        chk("rst_core_key", core_key, RESET_KEY);
        chk("rst_core_text", core_text, 128'(0));
        @(posedge clk);
        #1;

        // default key encrypt
        send_part(PT0, 1'b0, 1'b0, 0, 15);
        wait_idle("t1_idle");
        chk("t1_result", out_cap, CT0);

        // decrypt request
        send_part(CT0, 1'b0, 1'b1, 0, 15);
        wait_idle("t2_idle");
`ifdef AES_SEQ_DECRYPT_EN
        chk("t2_decrypt", out_cap, PT0);
`else
        chk("t2_dec_ignored", out_cap, aes_enc(RESET_KEY, CT0));
`endif

        // key load, core_key must hold until the 16th byte
        send_part(KEY1, 1'b1, 1'b0, 0, 7);
        @(negedge clk);
        chk("t3_key_partial", core_key, RESET_KEY);
        @(posedge clk);
        #1;
        send_part(KEY1, 1'b1, 1'b0, 8, 15);
        @(negedge clk);
        chk("t3_key_loaded", core_key, KEY1);
        chk("t3_key_no_out", 128'(bus.busy), 128'(0));
        @(posedge clk);
        #1;
        send_part(PT1, 1'b0, 1'b0, 0, 15);
        wait_idle("t3_idle");
        chk("t3_result", out_cap, CT1);

        // random backpressure with junk input offered during unload
        send_part(PT1, 1'b0, 1'b0, 0, 15);
        n = 0;
        while (bus.busy && n <= 400) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (n > 400) timeout("t4_idle");
        chk("t4_result", out_cap, CT1);

        // clear during partial key, then during partial data
        send_part(RESET_KEY, 1'b1, 1'b0, 0, 4);
        pulse_clear();
        chk("t5_key_kept", core_key, KEY1);
        send_part(PT0, 1'b0, 1'b0, 0, 6);
        pulse_clear();
        send_part(PT1, 1'b0, 1'b0, 0, 15);
        wait_idle("t5_idle");
        chk("t5_result", out_cap, CT1);

        // clear during unload after three bytes
        send_part(PT1, 1'b0, 1'b0, 0, 15);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) timeout("t6_out_valid");
        repeat (3) @(posedge clk);
        #1;
        pulse_clear();

        // async reset mid-RUN
        send_part(PT1, 1'b0, 1'b0, 0, 15);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("arst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_out_data", 128'(bus.out_data), 128'(0));
        chk("arst_core_key", core_key, RESET_KEY);
        chk("arst_core_text", core_text, 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_part(PT0, 1'b0, 1'b0, 0, 15);
        wait_idle("t7_idle");
        chk("t7_result", out_cap, CT0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
